// File: rtl/hc595_scan_pkg.sv
// Shared definitions for the 74HC595 7-segment scan controller:
// FSM state encoding, idle/off constants and the hex-to-segment table.
package hc595_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DWELL     = 3'd5
    } scan_state_e;

    // Active-low segment byte with every segment (and dp) dark.
    localparam logic [7:0]  SEG_OFF   = 8'hFF;
    // Word presented to the driver while nothing has been loaded yet.
    localparam logic [15:0] IDLE_WORD = 16'hFF00;

    // Active-high segment codes {g,f,e,d,c,b,a}, indexed by hex nibble.
    // Entry 0 is the least significant byte.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

    // One-hot digit select for a scan position.
    function automatic logic [7:0] digit_sel(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment byte {dp,g,f,e,d,c,b,a}.
module hex_to_seg7
    import hc595_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_n_o
);

    // Look up the active-high code, merge the decimal point, then invert.
    always_comb begin
        seg_n_o = ~(SEG_TABLE[nibble_i] | {dp_i, 7'b000_0000});
    end

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scanner that sequences a 74HC595 serial driver.
// One position per scan slot: build {segments, digit-select}, pulse lock,
// wait for the driver's busy window, then hold the digit for a dwell time.
// Optional build macro HC595_SCAN_LZB_EN enables leading-zero blanking.
module hc595_scan_ctrl
    import hc595_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 1000,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    busy,
    output logic [15:0]             data,
    output logic                    lock,
    output logic [2:0]              scan_idx,
    output logic                    frame_done
);

    // One shared counter serves both the ack timeout and the dwell period.
    localparam int CNT_MAX = (DWELL_CYCLES > ACK_TIMEOUT) ? DWELL_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // START takes one cycle, so WAIT_ACK lasts ACK_TIMEOUT-1 cycles and the
    // retry pulse lands exactly ACK_TIMEOUT cycles after the previous one.
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 2);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;
    logic [2:0]       idx_q, idx_d;
    logic             frame_q, frame_d;

    // Inputs padded to the full 8-position range so the 3-bit index is always in range.
    logic [31:0] digits_pad;
    logic [7:0]  dp_pad;
    logic [7:0]  blank_pad;
    logic [7:0]  lzb_dark;

    assign digits_pad = 32'(digits);
    assign dp_pad     = 8'(dp);
    assign blank_pad  = 8'(blank);

`ifdef HC595_SCAN_LZB_EN
    // A position goes dark when it and everything above it is zero; the
    // zero padding above NUM_DIGITS makes the top position work unchanged.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lzb
            if (gi == 0) begin : g_pos0
                assign lzb_dark[gi] = 1'b0;
            end else begin : g_posn
                assign lzb_dark[gi] = (digits_pad[31:4*gi] == '0);
            end
        end
    endgenerate
`else
    assign lzb_dark = '0;
`endif

    // Position mux feeding the single segment decoder.
    logic [3:0]  cur_nib;
    logic        cur_dark;
    logic        cur_dp;
    logic [7:0]  seg_n;
    logic [15:0] load_word;

    assign cur_nib  = digits_pad[{idx_q, 2'b00} +: 4];
    assign cur_dark = blank_pad[idx_q] | lzb_dark[idx_q];
    // A dark position also suppresses its decimal point.
    assign cur_dp   = dp_pad[idx_q] & ~cur_dark;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .seg_n_o  (seg_n)
    );

    assign load_word = {(cur_dark ? SEG_OFF : seg_n), digit_sel(idx_q)};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the load / handshake / dwell sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (en) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_START;
            ST_START:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (busy)                 state_d = ST_WAIT_DONE;
                else if (cnt_q == ACK_LAST) state_d = ST_START;
            end
            ST_WAIT_DONE: if (!busy) state_d = ST_DWELL;
            ST_DWELL: begin
                if (cnt_q == DWELL_LAST) state_d = en ? ST_LOAD : ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: lock is a one-cycle pulse per START visit.
    always_comb begin
        lock = (state_q == ST_START);
    end

    // Datapath next values: word capture, timers, position advance, frame pulse.
    always_comb begin
        cnt_d   = '0;
        data_d  = data_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        case (state_q)
            ST_LOAD: data_d = load_word;
            ST_WAIT_ACK: begin
                if (!busy && cnt_q != ACK_LAST) cnt_d = cnt_q + CNT_W'(1);
            end
            ST_DWELL: begin
                if (cnt_q != DWELL_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (idx_q == IDX_LAST) begin
                    idx_d   = 3'd0;
                    frame_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            data_q  <= IDLE_WORD;
            idx_q   <= 3'd0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign data       = data_q;
    assign scan_idx   = idx_q;
    assign frame_done = frame_q;

endmodule
